// File: rtl/misr_sig_analyzer_if.sv
`default_nettype none
// =============================================================================
// misr_sig_analyzer_if : run control, response bus and result bus of the MISR
// Rev 1.0
// =============================================================================
interface misr_sig_analyzer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic             resp_valid;
    logic [WIDTH-1:0] resp;
    logic [WIDTH-1:0] golden;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [15:0]      count;

    modport master (
        output start, abort, resp_valid, resp, golden,
        input  busy, done, pass, signature, count
    );

    modport slave (
        input  start, abort, resp_valid, resp, golden,
        output busy, done, pass, signature, count
    );
endinterface
`default_nettype wire

// File: rtl/misr_sig_analyzer.sv
`default_nettype none
// =============================================================================
// misr_sig_analyzer : MISR response compactor with BIST run control and
//                     golden-signature compare
// Rev 1.0
// =============================================================================
module misr_sig_analyzer #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] POLY       = 4'b0011,
    parameter logic [WIDTH-1:0] SEED       = 4'b0000,
    parameter int               N_PATTERNS = 15
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    misr_sig_analyzer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [15:0] c_last_count = 16'(N_PATTERNS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [15:0]      count_q, count_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] w_misr_next;

    // Shift left, fold the dropped MSB back through the taps, then mix in the response.
    assign w_misr_next = {sig_q[WIDTH-2:0], 1'b0}
                       ^ (sig_q[WIDTH-1] ? POLY : '0)
                       ^ bus.resp;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        pass_d  = pass_q;
        if (bus.abort) begin
            // Signature and count are left frozen so a debugger can inspect them.
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                        sig_d   = SEED;
                        count_d = '0;
                        pass_d  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.resp_valid) begin
                        sig_d   = w_misr_next;
                        count_d = count_q + 16'd1;
                        if (count_q == c_last_count) begin
                            state_d = S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    pass_d  = (sig_q == bus.golden);
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.busy      = (state_q == S_RUN) || (state_q == S_COMPARE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pass      = (state_q == S_DONE) && pass_q;
    assign bus.signature = sig_q;
    assign bus.count     = count_q;

endmodule
`default_nettype wire
